lstm_cell_update: RTL and testbench

- Downstream consumer of the sigmoid/tanh LUT-interpolation stage in the denoise recurrent datapath.
- Takes the four gate activations for one hidden unit (i, f, o already sigmoided; g already tanh'd) and updates that unit's cell state: c_new = f*c_old + i*g.
- Obtains tanh(c_new) through a request/response port to the shared tanh unit, then emits h = o*tanh(c_new).
- Holds cell state for all HIDDEN units across time steps; all arithmetic is signed Q16.16.

---
 rtl/lstm_fx_pkg.sv | 30 +++
 rtl/lstm_cell_update_if.sv | 44 ++++
 rtl/lstm_cell_update_fx_mul_sat.sv | 28 ++
 rtl/lstm_cell_update.sv | 150 +++++++++++++++
 tb/tb_lstm_cell_update.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_fx_pkg.sv
// Shared Q16.16 constants, FSM state encoding and gate payload for the LSTM cell-update block.
package lstm_fx_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned FRAC   = 16;
    localparam int unsigned HIDDEN = 16;
    localparam int unsigned IDX_W  = $clog2(HIDDEN);

    localparam logic [WIDTH-1:0] ONE     = 32'h0001_0000;
    localparam logic [WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_TREQ  = 3'd2,
        ST_TWAIT = 3'd3,
        ST_HCALC = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

    // Gate activations for one hidden unit
    typedef struct packed {
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] o;
    } gates_t;

endpackage

// File: rtl/lstm_cell_update_if.sv
// Handshake bundle of the cell-update block: gate input, tanh request/response, result output.
interface lstm_cell_update_if;
    import lstm_fx_pkg::*;

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [WIDTH-1:0] in_i;
    logic [WIDTH-1:0] in_f;
    logic [WIDTH-1:0] in_g;
    logic [WIDTH-1:0] in_o;

    logic             tanh_req_valid;
    logic             tanh_req_ready;
    logic [WIDTH-1:0] tanh_req_data;
    logic             tanh_rsp_valid;
    logic [WIDTH-1:0] tanh_rsp_data;

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_h;
    logic [WIDTH-1:0] out_c;

    // Environment side: producer of gates, tanh unit and result consumer
    modport master (
        output clear, in_valid, in_idx, in_i, in_f, in_g, in_o,
        output tanh_req_ready, tanh_rsp_valid, tanh_rsp_data,
        output out_ready,
        input  in_ready, tanh_req_valid, tanh_req_data,
        input  out_valid, out_idx, out_h, out_c
    );

    // Cell-update block side
    modport slave (
        input  clear, in_valid, in_idx, in_i, in_f, in_g, in_o,
        input  tanh_req_ready, tanh_rsp_valid, tanh_rsp_data,
        input  out_ready,
        output in_ready, tanh_req_valid, tanh_req_data,
        output out_valid, out_idx, out_h, out_c
    );

endinterface

// File: rtl/lstm_cell_update_fx_mul_sat.sv
// Combinational signed Q16.16 multiply with saturation of the rescaled product.
module fx_mul_sat
    import lstm_fx_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] prod_c_o
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] full;

    // Full product, then keep [47:16] (floor) unless the upper bits show overflow
    always_comb begin
        a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
        b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
        full  = a_ext * b_ext;
        if (!full[2*WIDTH-1] && (|full[2*WIDTH-2:WIDTH+FRAC-1])) begin
            prod_c_o = SAT_MAX;
        end else if (full[2*WIDTH-1] && !(&full[2*WIDTH-2:WIDTH+FRAC-1])) begin
            prod_c_o = SAT_MIN;
        end else begin
            prod_c_o = full[WIDTH+FRAC-1:FRAC];
        end
    end

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell-state update: c_new = f*c_old + i*g, then h = o*tanh(c_new) via the shared tanh unit.
module lstm_cell_update
    import lstm_fx_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    lstm_cell_update_if.slave  bus_if
);

    state_e           state_q, state_d;
    gates_t           gates_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [WIDTH-1:0] c_old_q;
    logic [WIDTH-1:0] tanh_q;
    logic [WIDTH-1:0] req_data_q;
    logic [WIDTH-1:0] out_h_q;
    logic [WIDTH-1:0] out_c_q;
    logic [HIDDEN-1:0] vld_q;
    logic [WIDTH-1:0] c_mem [HIDDEN];
    logic             clr_pend_q;
    logic             req_valid_q;
    logic             out_valid_q;

    logic             in_ready_c;
    logic             accept_c;
    logic             clr_now_c;
    logic [WIDTH-1:0] fc_c;
    logic [WIDTH-1:0] ig_c;
    logic [WIDTH-1:0] oh_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] c_new_c;

    fx_mul_sat u_mul_fc (.a_i(gates_q.f), .b_i(c_old_q), .prod_c_o(fc_c));
    fx_mul_sat u_mul_ig (.a_i(gates_q.i), .b_i(gates_q.g), .prod_c_o(ig_c));
    fx_mul_sat u_mul_oh (.a_i(gates_q.o), .b_i(tanh_q),    .prod_c_o(oh_c));

    // 33-bit sign-extended add; a sign mismatch in the top two bits means overflow
    always_comb begin
        sum_c = {fc_c[WIDTH-1], fc_c} + {ig_c[WIDTH-1], ig_c};
        if (sum_c[WIDTH] != sum_c[WIDTH-1]) begin
            c_new_c = sum_c[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            c_new_c = sum_c[WIDTH-1:0];
        end
    end

    // Next-state and handshake decode; a clear (live or pending) blocks acceptance in IDLE
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept_c   = 1'b0;
        clr_now_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_now_c  = bus_if.clear | clr_pend_q;
                in_ready_c = rst_n & ~clr_now_c;
                accept_c   = in_ready_c & bus_if.in_valid;
                if (accept_c) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC:  state_d = ST_TREQ;
            ST_TREQ:  if (bus_if.tanh_req_ready) state_d = ST_TWAIT;
            ST_TWAIT: if (bus_if.tanh_rsp_valid) state_d = ST_HCALC;
            ST_HCALC: state_d = ST_OUT;
            ST_OUT:   if (bus_if.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered valids, pending clear and the per-entry valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            vld_q       <= '0;
        end else begin
            req_valid_q <= (state_d == ST_TREQ);
            out_valid_q <= (state_d == ST_OUT);
            if (state_q == ST_IDLE) begin
                clr_pend_q <= 1'b0;
            end else if (bus_if.clear) begin
                clr_pend_q <= 1'b1;
            end
            if (clr_now_c) begin
                vld_q <= '0;
            end else if (state_q == ST_CALC) begin
                vld_q[idx_q] <= 1'b1;
            end
        end
    end

    // Datapath capture: bundle on accept, c_new in CALC, tanh in TWAIT, results in HCALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gates_q    <= '0;
            idx_q      <= '0;
            c_old_q    <= '0;
            tanh_q     <= '0;
            req_data_q <= '0;
            out_h_q    <= '0;
            out_c_q    <= '0;
            out_idx_q  <= '0;
        end else begin
            if (accept_c) begin
                idx_q   <= bus_if.in_idx;
                gates_q <= '{i: bus_if.in_i, f: bus_if.in_f, g: bus_if.in_g, o: bus_if.in_o};
                c_old_q <= vld_q[bus_if.in_idx] ? c_mem[bus_if.in_idx] : '0;
            end
            if (state_q == ST_CALC) begin
                req_data_q <= c_new_c;
            end
            if ((state_q == ST_TWAIT) && bus_if.tanh_rsp_valid) begin
                tanh_q <= bus_if.tanh_rsp_data;
            end
            if (state_q == ST_HCALC) begin
                out_h_q   <= oh_c;
                out_c_q   <= req_data_q;
                out_idx_q <= idx_q;
            end
        end
    end

    // Cell-state storage; contents are qualified by vld_q so no reset is needed
    always_ff @(posedge clk) begin
        if (state_q == ST_CALC) begin
            c_mem[idx_q] <= c_new_c;
        end
    end

    assign bus_if.in_ready       = in_ready_c;
    assign bus_if.tanh_req_valid = req_valid_q;
    assign bus_if.tanh_req_data  = req_data_q;
    assign bus_if.out_valid      = out_valid_q;
    assign bus_if.out_idx        = out_idx_q;
    assign bus_if.out_h          = out_h_q;
    assign bus_if.out_c          = out_c_q;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Self-checking bench for lstm_cell_update: directed scenarios plus randomized updates vs. a Q16.16 model.
module tb_lstm_cell_update;
    import lstm_fx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lstm_cell_update_if bus ();

    lstm_cell_update dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_c   [HIDDEN];
    bit          model_vld [HIDDEN];

    // Reference arithmetic: exact integer math, floor shift, clamp to 32-bit signed
    function automatic logic [31:0] clamp64(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return clamp64(p >>> 16);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return clamp64(longint'($signed(a)) + longint'($signed(b)));
    endfunction

    function automatic logic [31:0] model_cnew(input logic [3:0] idx, input logic [31:0] gi,
                                               input logic [31:0] gf, input logic [31:0] gg);
        logic [31:0] c_old;
        c_old = model_vld[idx] ? model_c[idx] : 32'h0;
        return ref_add(ref_mul(gf, c_old), ref_mul(gi, gg));
    endfunction

    task automatic model_write(input logic [3:0] idx, input logic [31:0] c);
        model_c[idx]   = c;
        model_vld[idx] = 1'b1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < int'(HIDDEN); k++) model_vld[k] = 1'b0;
    endtask

    // Drive one bundle through the full handshake sequence and capture what the DUT produced
    task automatic do_op(input logic [3:0] idx, input logic [31:0] gi, input logic [31:0] gf,
                         input logic [31:0] gg, input logic [31:0] go, input logic [31:0] tv,
                         input int rsp_lat,
                         output logic [31:0] req_d, output logic [31:0] hv, output logic [31:0] cv,
                         output logic [3:0] oi, output int req_cyc, output bit ok);
        int n;
        ok = 1'b1; req_d = '0; hv = '0; cv = '0; oi = '0; req_cyc = 0;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (bus.in_ready !== 1'b1) begin ok = 1'b0; return; end
        bus.in_valid = 1'b1; bus.in_idx = idx;
        bus.in_i = gi; bus.in_f = gf; bus.in_g = gg; bus.in_o = go;
        @(negedge clk);
        bus.in_valid = 1'b0;
        req_cyc = 1; n = 0;
        while (bus.tanh_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; req_cyc++; end
        if (bus.tanh_req_valid !== 1'b1) begin ok = 1'b0; return; end
        req_d = bus.tanh_req_data;
        bus.tanh_req_ready = 1'b1;
        @(negedge clk);
        bus.tanh_req_ready = 1'b0;
        repeat (rsp_lat) @(negedge clk);
        bus.tanh_rsp_valid = 1'b1; bus.tanh_rsp_data = tv;
        @(negedge clk);
        bus.tanh_rsp_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (bus.out_valid !== 1'b1) begin ok = 1'b0; return; end
        hv = bus.out_h; cv = bus.out_c; oi = bus.out_idx;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({bus.in_ready, bus.tanh_req_valid, bus.out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000", {bus.in_ready, bus.tanh_req_valid, bus.out_valid});
        end
        n_tests++;
        if ({bus.tanh_req_data, bus.out_h, bus.out_c, bus.out_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_data req=%h h=%h c=%h idx=%0d want all 0",
                     bus.tanh_req_data, bus.out_h, bus.out_c, bus.out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] rq, h, c; logic [3:0] oi; int rc; bit ok;
        do_op(4'd3, ONE, 32'h0, 32'h0002_0000, 32'h0, 32'h0, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h0002_0000) begin
            n_fail++; $display("FAIL basic_preload ok=%0d c=%h want 00020000", ok, c);
        end
        model_write(4'd3, 32'h0002_0000);
        do_op(4'd3, ONE, 32'h0000_8000, 32'h0000_4000, 32'h0000_8000, 32'h0000_D000, 1, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || rq !== 32'h0001_4000) begin
            n_fail++; $display("FAIL basic_req_data ok=%0d got=%h want 00014000", ok, rq);
        end
        n_tests++;
        if (rc !== 2) begin
            n_fail++; $display("FAIL basic_req_latency got=%0d want 2", rc);
        end
        n_tests++;
        if (h !== 32'h0000_6800 || c !== 32'h0001_4000 || oi !== 4'd3) begin
            n_fail++; $display("FAIL basic_out h=%h c=%h idx=%0d want 00006800 00014000 3", h, c, oi);
        end
        model_write(4'd3, 32'h0001_4000);
    endtask

    task automatic test_fresh_clear();
        logic [31:0] rq, h, c; logic [3:0] oi; int rc; bit ok; bit seen;
        do_op(4'd5, ONE, ONE, 32'h0000_8000, ONE, 32'h0, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h0000_8000) begin
            n_fail++; $display("FAIL fresh_c ok=%0d got=%h want 00008000", ok, c);
        end
        model_write(4'd5, 32'h0000_8000);
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_idx = 4'd5;
        bus.in_i = ONE; bus.in_f = ONE; bus.in_g = 32'h0000_8000; bus.in_o = ONE;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL clear_blocks_ready got=%b want 0", bus.in_ready);
        end
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.tanh_req_valid !== 1'b0) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL clear_bundle_dropped req_valid seen=1 want 0");
        end
        do_op(4'd5, ONE, ONE, 32'h0000_8000, ONE, 32'h0, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h0000_8000) begin
            n_fail++; $display("FAIL clear_c ok=%0d got=%h want 00008000", ok, c);
        end
        model_write(4'd5, c);
    endtask

    task automatic test_saturation();
        logic [31:0] rq, h, c; logic [3:0] oi; int rc; bit ok;
        do_op(4'd1, ONE, 32'h0, 32'h7FFF_0000, 32'h0, 32'h0, 0, rq, h, c, oi, rc, ok);
        model_write(4'd1, c);
        do_op(4'd1, ONE, ONE, ONE, 32'h0002_0000, 32'h7FFF_0000, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h7FFF_FFFF || h !== 32'h7FFF_FFFF) begin
            n_fail++; $display("FAIL sat_pos ok=%0d c=%h h=%h want 7fffffff 7fffffff", ok, c, h);
        end
        model_write(4'd1, 32'h7FFF_FFFF);
        do_op(4'd2, ONE, 32'h0, 32'h8001_0000, 32'h0, 32'h0, 0, rq, h, c, oi, rc, ok);
        model_write(4'd2, c);
        do_op(4'd2, ONE, ONE, 32'hFFFF_0000, 32'h0002_0000, 32'h8001_0000, 2, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h8000_0000 || h !== 32'h8000_0000) begin
            n_fail++; $display("FAIL sat_neg ok=%0d c=%h h=%h want 80000000 80000000", ok, c, h);
        end
        model_write(4'd2, 32'h8000_0000);
    endtask

    task automatic test_neg_trunc();
        logic [31:0] rq, h, c; logic [3:0] oi; int rc; bit ok;
        do_op(4'd9, ONE, 32'h0, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL neg_trunc ok=%0d c=%h h=%h want ffffffff ffffffff", ok, c, h);
        end
        model_write(4'd9, 32'hFFFF_FFFF);
    endtask

    task automatic test_backpressure();
        logic [31:0] rq, h, c, exp_c, exp_h; logic [3:0] oi; int rc, n; bit ok;
        exp_c = model_cnew(4'd4, ONE, ONE, 32'h0000_3000);
        exp_h = ref_mul(32'h0000_8000, 32'h0000_2000);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.in_valid = 1'b1; bus.in_idx = 4'd4;
        bus.in_i = ONE; bus.in_f = ONE; bus.in_g = 32'h0000_3000; bus.in_o = 32'h0000_8000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.tanh_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            bus.clear = (k == 2);
            n_tests++;
            if (bus.tanh_req_valid !== 1'b1 || bus.tanh_req_data !== exp_c || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_req_hold cyc=%0d valid=%b data=%h ready=%b want 1 %h 0",
                         k, bus.tanh_req_valid, bus.tanh_req_data, bus.in_ready, exp_c);
            end
            @(negedge clk);
        end
        bus.clear = 1'b0;
        bus.tanh_req_ready = 1'b1;
        @(negedge clk);
        bus.tanh_req_ready = 1'b0;
        bus.tanh_rsp_valid = 1'b1; bus.tanh_rsp_data = 32'h0000_2000;
        @(negedge clk);
        bus.tanh_rsp_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_h !== exp_h || bus.out_c !== exp_c || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_out_hold cyc=%0d valid=%b h=%h c=%h ready=%b want 1 %h %h 0",
                         k, bus.out_valid, bus.out_h, bus.out_c, bus.in_ready, exp_h, exp_c);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_pending_clear valid=%b ready=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        model_write(4'd4, exp_c);
        model_clear();
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_after_clear got=%b want 1", bus.in_ready);
        end
        do_op(4'd4, 32'h0, ONE, 32'h0, ONE, 32'h0, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h0) begin
            n_fail++; $display("FAIL bp_cleared_entry ok=%0d c=%h want 00000000", ok, c);
        end
        model_write(4'd4, 32'h0);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rq, h, c; logic [3:0] oi; int rc, n; bit ok, seen;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.in_valid = 1'b1; bus.in_idx = 4'd6;
        bus.in_i = ONE; bus.in_f = 32'h0; bus.in_g = 32'h0005_0000; bus.in_o = ONE;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.tanh_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        bus.tanh_req_ready = 1'b1;
        @(negedge clk);
        bus.tanh_req_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.tanh_req_valid, bus.out_valid} !== 3'b000 ||
            {bus.tanh_req_data, bus.out_h, bus.out_c, bus.out_idx} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset rdy=%b rv=%b ov=%b req=%h h=%h c=%h want all 0",
                     bus.in_ready, bus.tanh_req_valid, bus.out_valid, bus.tanh_req_data, bus.out_h, bus.out_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        bus.tanh_rsp_valid = 1'b1; bus.tanh_rsp_data = 32'h0000_1234;
        @(negedge clk);
        bus.tanh_rsp_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.out_valid !== 1'b0 || bus.tanh_req_valid !== 1'b0) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL midop_stale_rsp activity seen=1 want 0");
        end
        do_op(4'd6, ONE, ONE, 32'h0000_1000, ONE, 32'h0, 0, rq, h, c, oi, rc, ok);
        n_tests++;
        if (!ok || c !== 32'h0000_1000) begin
            n_fail++; $display("FAIL midop_entry_zero ok=%0d c=%h want 00001000", ok, c);
        end
        model_write(4'd6, c);
    endtask

    function automatic logic [31:0] rnd_gate();
        if ($urandom_range(0, 4) == 0) return 32'($urandom);
        return 32'($urandom_range(0, 32'h0002_0000)) - 32'h0001_0000;
    endfunction

    task automatic test_random();
        logic [31:0] rq, h, c, gi, gf, gg, go, tv, exp_c, exp_h; logic [3:0] oi, idx; int rc; bit ok;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.clear = 1'b1;
                @(negedge clk);
                bus.clear = 1'b0;
                model_clear();
            end
            idx = 4'($urandom_range(0, 3));
            gi = rnd_gate(); gf = rnd_gate(); gg = rnd_gate(); go = rnd_gate(); tv = rnd_gate();
            exp_c = model_cnew(idx, gi, gf, gg);
            exp_h = ref_mul(go, tv);
            do_op(idx, gi, gf, gg, go, tv, $urandom_range(0, 3), rq, h, c, oi, rc, ok);
            n_tests++;
            if (!ok || rq !== exp_c || c !== exp_c) begin
                n_fail++; $display("FAIL rand_c it=%0d ok=%0d req=%h c=%h want %h", it, ok, rq, c, exp_c);
            end
            n_tests++;
            if (h !== exp_h || oi !== idx) begin
                n_fail++; $display("FAIL rand_h it=%0d h=%h idx=%0d want %h %0d", it, h, oi, exp_h, idx);
            end
            model_write(idx, exp_c);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_idx = '0;
        bus.in_i = '0; bus.in_f = '0; bus.in_g = '0; bus.in_o = '0;
        bus.tanh_req_ready = 1'b0; bus.tanh_rsp_valid = 1'b0; bus.tanh_rsp_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_fresh_clear();
        test_saturation();
        test_neg_trunc();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
